id_alloc_table: RTL and testbench

Parametrised ID-remapping table for the ROB front end. It maps each incoming original transaction ID to a unique ID `{row, col}`. All outstanding transactions sharing an original ID live in one bound row, which keeps their ordering; each column of that row is one in-flight slot. On completion the unique ID is freed and the original ID is returned as a registered response. Compared with the previous allocator, this block adds:
- independent row and column depth;
- per-slot occupancy tracking;
- stall on a full hit-row instead of overwrite;
- illegal-free detection;
- correct simultaneous alloc/free accounting;
- occupancy status outputs.

---
 rtl/id_alloc_pkg.sv | 26 ++
 rtl/id_alloc_table_prio_enc.sv | 23 ++
 rtl/id_alloc_table.sv | 175 +++++++++++++++++
 tb/tb_id_alloc_table.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_alloc_pkg.sv
// Shared constants, uid split helpers and the free-response record for the
// ROB front-end ID remapping table.
package id_alloc_pkg;

    localparam int DEF_ID_WIDTH  = 4;
    localparam int DEF_NUM_ROWS  = 4;
    localparam int DEF_NUM_COLS  = 4;
    localparam int DEF_UID_WIDTH = $clog2(DEF_NUM_ROWS) + $clog2(DEF_NUM_COLS);

    typedef struct packed {
        logic                     valid;
        logic [DEF_ID_WIDTH-1:0]  orig_id;
        logic [DEF_UID_WIDTH-1:0] uid;
        logic                     err;
    } free_rsp_t;

    // A unique ID is {row, col}; col occupies the low col_w bits.
    function automatic int uid_row(input int unsigned uid, input int col_w);
        return int'(uid >> col_w);
    endfunction

    function automatic int uid_col(input int unsigned uid, input int col_w);
        return int'(uid & ((32'd1 << col_w) - 32'd1));
    endfunction

endpackage

// File: rtl/id_alloc_table_prio_enc.sv
// Lowest-index priority encoder with a found flag.
module prio_enc #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_alloc_table.sv
// Remaps original transaction IDs to unique {row, col} IDs. One bound row per
// original ID keeps ordering; each column is one in-flight slot.
module id_alloc_table
    import id_alloc_pkg::*;
#(
    parameter int ID_WIDTH = DEF_ID_WIDTH,
    parameter int NUM_ROWS = DEF_NUM_ROWS,
    parameter int NUM_COLS = DEF_NUM_COLS,
    localparam int ROW_W     = $clog2(NUM_ROWS),
    localparam int COL_W     = $clog2(NUM_COLS),
    localparam int UID_WIDTH = ROW_W + COL_W,
    localparam int CNT_W     = $clog2(NUM_ROWS * NUM_COLS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Alloc: transfer happens on alloc_valid && alloc_ready; ready never looks at free_*.
    input  logic                 alloc_valid,
    input  logic [ID_WIDTH-1:0]  alloc_orig_id,
    output logic                 alloc_ready,
    output logic [UID_WIDTH-1:0] alloc_uid,
    input  logic                 free_valid,
    input  logic [UID_WIDTH-1:0] free_uid,
    output logic                 free_rsp_valid,
    output logic [ID_WIDTH-1:0]  free_rsp_orig_id,
    output logic [UID_WIDTH-1:0] free_rsp_uid,
    output logic                 free_rsp_err,
    output logic [CNT_W-1:0]     outstanding_cnt,
    output logic                 full,
    output logic                 empty
);

    localparam int NUM_SLOTS = NUM_ROWS * NUM_COLS;
    localparam int RCNT_W    = COL_W + 1;

    logic [NUM_ROWS-1:0] r_bound;
    logic [ID_WIDTH-1:0] r_bound_id [NUM_ROWS];
    logic [COL_W-1:0]    r_col_ptr  [NUM_ROWS];
    logic [RCNT_W-1:0]   r_row_cnt  [NUM_ROWS];
    logic [NUM_SLOTS-1:0] r_slot_busy;
    logic [ID_WIDTH-1:0] r_slot_id  [NUM_SLOTS];
    logic [CNT_W-1:0]    r_cnt;

    logic                 r_rsp_valid;
    logic [ID_WIDTH-1:0]  r_rsp_orig_id;
    logic [UID_WIDTH-1:0] r_rsp_uid;
    logic                 r_rsp_err;

    logic [NUM_ROWS-1:0]  w_hit_vec;
    logic [NUM_ROWS-1:0]  w_unbound_vec;
    logic [ROW_W-1:0]     w_hit_idx;
    logic [ROW_W-1:0]     w_unb_idx;
    logic                 w_hit_found;
    logic                 w_unb_found;
    logic [ROW_W-1:0]     w_tgt_row;
    logic [COL_W-1:0]     w_tgt_col;
    logic                 w_fire;
    logic [ROW_W-1:0]     w_free_row;
    logic [COL_W-1:0]     w_free_col;
    logic [UID_WIDTH-1:0] w_free_slot;
    logic                 w_free_busy;
    logic                 w_free_legal;
    logic [NUM_ROWS-1:0]  w_row_inc;
    logic [NUM_ROWS-1:0]  w_row_dec;
    logic [RCNT_W-1:0]    w_row_cnt_nxt [NUM_ROWS];

    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_hit_vec[r] = r_bound[r] && (r_bound_id[r] == alloc_orig_id);
        end
    end

    assign w_unbound_vec = ~r_bound;

    prio_enc #(.N(NUM_ROWS)) u_hit_enc (
        .i_req   (w_hit_vec),
        .o_idx   (w_hit_idx),
        .o_found (w_hit_found)
    );

    prio_enc #(.N(NUM_ROWS)) u_unbound_enc (
        .i_req   (w_unbound_vec),
        .o_idx   (w_unb_idx),
        .o_found (w_unb_found)
    );

    // A hit row never falls back to a fresh row: a full hit-row stalls.
    assign w_tgt_row   = w_hit_found ? w_hit_idx : w_unb_idx;
    assign w_tgt_col   = r_col_ptr[w_tgt_row];
    assign alloc_uid   = {w_tgt_row, w_tgt_col};
    assign alloc_ready = w_hit_found ? !r_slot_busy[alloc_uid] : w_unb_found;
    assign w_fire      = alloc_valid && alloc_ready;

    assign w_free_row   = ROW_W'(uid_row(32'(free_uid), COL_W));
    assign w_free_col   = COL_W'(uid_col(32'(free_uid), COL_W));
    assign w_free_slot  = {w_free_row, w_free_col};
    assign w_free_busy  = r_slot_busy[w_free_slot];
    assign w_free_legal = free_valid && w_free_busy;

    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_row_inc[r]     = w_fire && (w_tgt_row == ROW_W'(r));
            w_row_dec[r]     = w_free_legal && (w_free_row == ROW_W'(r));
            w_row_cnt_nxt[r] = r_row_cnt[r] + RCNT_W'(w_row_inc[r]) - RCNT_W'(w_row_dec[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bound <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                r_bound_id[r] <= '0;
                r_col_ptr[r]  <= '0;
                r_row_cnt[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                r_row_cnt[r] <= w_row_cnt_nxt[r];
                if (w_row_cnt_nxt[r] == '0) begin
                    r_bound[r]    <= 1'b0;
                    r_bound_id[r] <= '0;
                    r_col_ptr[r]  <= '0;
                end else if (w_row_inc[r]) begin
                    r_bound[r]    <= 1'b1;
                    r_bound_id[r] <= alloc_orig_id;
                    r_col_ptr[r]  <= r_col_ptr[r] + COL_W'(1);
                end
            end
        end
    end

    // Alloc and legal free never target the same slot, so set and clear are disjoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_busy <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                r_slot_id[s] <= '0;
            end
        end else begin
            if (w_fire) begin
                r_slot_busy[alloc_uid] <= 1'b1;
                r_slot_id[alloc_uid]   <= alloc_orig_id;
            end
            if (w_free_legal) begin
                r_slot_busy[w_free_slot] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_orig_id <= '0;
            r_rsp_uid     <= '0;
            r_rsp_err     <= 1'b0;
        end else begin
            r_cnt       <= r_cnt + CNT_W'(w_fire) - CNT_W'(w_free_legal);
            r_rsp_valid <= free_valid;
            r_rsp_err   <= free_valid && !w_free_busy;
            if (free_valid) begin
                r_rsp_orig_id <= r_slot_id[w_free_slot];
                r_rsp_uid     <= free_uid;
            end
        end
    end

    assign free_rsp_valid   = r_rsp_valid;
    assign free_rsp_orig_id = r_rsp_orig_id;
    assign free_rsp_uid     = r_rsp_uid;
    assign free_rsp_err     = r_rsp_err;
    assign outstanding_cnt  = r_cnt;
    assign full             = (r_cnt == CNT_W'(NUM_SLOTS));
    assign empty            = (r_cnt == '0);

endmodule

// File: tb/tb_id_alloc_table.sv
// Directed bench for id_alloc_table: grants checked at the request, free
// responses matched against a queue of expected records.
module tb_id_alloc_table;
    import id_alloc_pkg::*;

    localparam int IDW   = 4;
    localparam int UIDW  = 4;
    localparam int CNTW  = 5;
    localparam int RSP_W = IDW + UIDW + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            alloc_valid = 1'b0;
    logic [IDW-1:0]  alloc_orig_id = '0;
    logic            alloc_ready;
    logic [UIDW-1:0] alloc_uid;
    logic            free_valid = 1'b0;
    logic [UIDW-1:0] free_uid = '0;
    logic            free_rsp_valid;
    logic [IDW-1:0]  free_rsp_orig_id;
    logic [UIDW-1:0] free_rsp_uid;
    logic            free_rsp_err;
    logic [CNTW-1:0] outstanding_cnt;
    logic            full;
    logic            empty;

    int n_checks = 0;
    int n_err    = 0;
    logic [RSP_W-1:0] exp_q[$];
    logic [RSP_W-1:0] mon_exp;
    free_rsp_t        mon_got;

    id_alloc_table dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_valid      (alloc_valid),
        .alloc_orig_id    (alloc_orig_id),
        .alloc_ready      (alloc_ready),
        .alloc_uid        (alloc_uid),
        .free_valid       (free_valid),
        .free_uid         (free_uid),
        .free_rsp_valid   (free_rsp_valid),
        .free_rsp_orig_id (free_rsp_orig_id),
        .free_rsp_uid     (free_rsp_uid),
        .free_rsp_err     (free_rsp_err),
        .outstanding_cnt  (outstanding_cnt),
        .full             (full),
        .empty            (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks run 1 time unit later.
    task automatic drive(input logic av, input logic [IDW-1:0] aid,
                         input logic fv, input logic [UIDW-1:0] fuid);
        @(negedge clk);
        alloc_valid   = av;
        alloc_orig_id = aid;
        free_valid    = fv;
        free_uid      = fuid;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic alloc_ok(input string tag, input logic [IDW-1:0] id, input logic [UIDW-1:0] exp_uid);
        drive(1'b1, id, 1'b0, '0);
        check({tag, "_ready"}, alloc_ready, 1);
        check({tag, "_uid"}, alloc_uid, exp_uid);
    endtask

    task automatic alloc_blocked(input string tag, input logic [IDW-1:0] id);
        drive(1'b1, id, 1'b0, '0);
        check({tag, "_ready"}, alloc_ready, 0);
    endtask

    task automatic expect_rsp(input logic [UIDW-1:0] uid, input logic [IDW-1:0] orig, input logic err);
        exp_q.push_back({orig, uid, err});
    endtask

    task automatic free_one(input logic [UIDW-1:0] uid, input logic [IDW-1:0] orig, input logic err);
        drive(1'b0, '0, 1'b1, uid);
        expect_rsp(uid, orig, err);
    endtask

    task automatic check_counts(input string tag, input int cnt, input logic f, input logic e);
        check({tag, "_cnt"}, outstanding_cnt, cnt);
        check({tag, "_full"}, full, f);
        check({tag, "_empty"}, empty, e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        alloc_valid = 1'b0;
        free_valid  = 1'b0;
        rst_n       = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Response scoreboard: every pulse must match the oldest outstanding free.
    always @(negedge clk) begin
        if (rst_n && free_rsp_valid) begin
            mon_got = '{free_rsp_valid, free_rsp_orig_id, free_rsp_uid, free_rsp_err};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $error("FAIL rsp_unexpected uid=0x%0h orig=0x%0h", mon_got.uid, mon_got.orig_id);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rsp_orig", mon_got.orig_id, mon_exp[RSP_W-1 -: IDW]);
                check("rsp_uid", mon_got.uid, mon_exp[UIDW:1]);
                check("rsp_err", mon_got.err, mon_exp[0]);
            end
        end
    end

    initial begin
        // Reset values, including combinational grant under several IDs.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            alloc_orig_id = IDW'($urandom_range(0, 15));
            #1;
            check("rst_ready", alloc_ready, 1);
            check("rst_uid", alloc_uid, 0);
        end
        check("rst_rsp_valid", free_rsp_valid, 0);
        check("rst_rsp_err", free_rsp_err, 0);
        check("rst_rsp_orig", free_rsp_orig_id, 0);
        check("rst_rsp_uid", free_rsp_uid, 0);
        check_counts("rst", 0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Two IDs share a row, a third gets the next row.
        alloc_ok("a5_0", 4'd5, 4'h0);
        alloc_ok("a5_1", 4'd5, 4'h1);
        alloc_ok("a9_0", 4'd9, 4'h4);
        idle();
        check_counts("t1", 3, 1'b0, 1'b0);

        // Full hit-row stalls; no second row is bound to id 3.
        apply_reset();
        alloc_ok("a3_0", 4'd3, 4'h0);
        alloc_ok("a3_1", 4'd3, 4'h1);
        alloc_ok("a3_2", 4'd3, 4'h2);
        alloc_ok("a3_3", 4'd3, 4'h3);
        alloc_blocked("a3_full", 4'd3);
        alloc_ok("a4_0", 4'd4, 4'h4);
        idle();
        check_counts("t2", 5, 1'b0, 1'b0);

        // Illegal free, legal free, double free, back-to-back frees.
        free_one(4'h5, 4'd0, 1'b1);
        free_one(4'h1, 4'd3, 1'b0);
        free_one(4'h1, 4'd3, 1'b1);
        check("t3_cnt_after_frees", outstanding_cnt, 4);
        free_one(4'h2, 4'd3, 1'b0);
        free_one(4'h3, 4'd3, 1'b0);
        // Row 0 holds only col 0 and its pointer wrapped onto it.
        alloc_blocked("a3_wrap_busy", 4'd3);
        drive(1'b1, 4'd3, 1'b1, 4'h0);
        expect_rsp(4'h0, 4'd3, 1'b0);
        check("a3_unbinding_ready", alloc_ready, 0);
        alloc_ok("a3_rebind", 4'd3, 4'h0);
        idle();
        check_counts("t3", 2, 1'b0, 1'b0);

        // Simultaneous free of the only slot and alloc to the same row.
        apply_reset();
        alloc_ok("a7_0", 4'd7, 4'h0);
        drive(1'b1, 4'd7, 1'b1, 4'h0);
        expect_rsp(4'h0, 4'd7, 1'b0);
        check("a7_same_ready", alloc_ready, 1);
        check("a7_same_uid", alloc_uid, 4'h1);
        idle();
        check_counts("t4_same", 1, 1'b0, 1'b0);
        alloc_ok("a8_0", 4'd8, 4'h4);
        alloc_ok("a7_2", 4'd7, 4'h2);
        idle();
        check_counts("t4", 3, 1'b0, 1'b0);

        // All rows bound: new ID stalls until a row unbinds.
        apply_reset();
        alloc_ok("b1", 4'd1, 4'h0);
        alloc_ok("b2", 4'd2, 4'h4);
        alloc_ok("b3", 4'd3, 4'h8);
        alloc_ok("b4", 4'd4, 4'hC);
        alloc_blocked("b5_norow", 4'd5);
        drive(1'b1, 4'd5, 1'b1, 4'h8);
        expect_rsp(4'h8, 4'd3, 1'b0);
        check("b5_unbinding_ready", alloc_ready, 0);
        alloc_ok("b5_row2", 4'd5, 4'h8);
        idle();
        check_counts("t5", 4, 1'b0, 1'b0);

        // Fill every slot.
        for (int c = 1; c < 4; c++) begin
            alloc_ok("f1", 4'd1, UIDW'(c));
            alloc_ok("f2", 4'd2, UIDW'(4 + c));
            alloc_ok("f5", 4'd5, UIDW'(8 + c));
            alloc_ok("f4", 4'd4, UIDW'(12 + c));
        end
        idle();
        check_counts("t6_full", 16, 1'b1, 1'b0);
        alloc_blocked("f1_rowfull", 4'd1);
        alloc_blocked("f9_tablefull", 4'd9);

        // Reset lands while a free is in flight; its response is dropped.
        @(negedge clk);
        alloc_valid = 1'b0;
        free_valid  = 1'b1;
        free_uid    = 4'h3;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_ready", alloc_ready, 1);
        check("mid_rst_uid", alloc_uid, 0);
        check_counts("mid_rst", 0, 1'b0, 1'b1);
        @(negedge clk);
        free_valid = 1'b0;
        check("mid_rst_rsp_valid", free_rsp_valid, 0);
        rst_n = 1'b1;
        free_one(4'h3, 4'd0, 1'b1);
        idle();
        check_counts("post_rst", 0, 1'b0, 1'b1);
        repeat (3) idle();
        check("q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
